// File: rtl/stream_demux_flushable.sv
// -----------------------------------------------------------------------------
// stream_demux_flushable
//
// Routes one valid/ready input stream to one of N_OUP output streams. The
// destination is chosen per beat by inp_sel_i, which travels with the data.
// Each output owns a 2-entry register buffer (head + tail). This gives full
// throughput and registered outputs, and it keeps every combinational path
// from oup_ready_i away from inp_ready_o. flush_i empties every buffer in a
// single cycle. A beat whose select is out of range is accepted and
// discarded, and drop_o pulses one cycle later.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset (priority over flush_i)
//   flush_i      synchronous flush, discards all buffered beats
//   inp_data_i   input payload
//   inp_sel_i    destination index, sampled together with inp_data_i
//   inp_valid_i  input valid
//   inp_ready_o  input ready (depends on occupancy and inp_sel_i only)
//   oup_data_o   per-output payload (head of each buffer)
//   oup_valid_o  per-output valid
//   oup_ready_i  per-output ready
//   drop_o       one-cycle pulse after an out-of-range beat was discarded
// -----------------------------------------------------------------------------
module stream_demux_flushable #(
    parameter type DATA_T = logic,
    parameter int  N_OUP  = 2,
    parameter int  SEL_W  = $clog2(N_OUP)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  DATA_T                  inp_data_i,
    input  logic [SEL_W-1:0]       inp_sel_i,
    input  logic                   inp_valid_i,
    output logic                   inp_ready_o,
    output DATA_T [N_OUP-1:0]      oup_data_o,
    output logic  [N_OUP-1:0]      oup_valid_o,
    input  logic  [N_OUP-1:0]      oup_ready_i,
    output logic                   drop_o
);

    logic [N_OUP-1:0] w_hit;    // one-hot decode of inp_sel_i (all zero if out of range)
    logic [N_OUP-1:0] w_full;   // buffer i holds two beats
    logic             w_legal;
    logic             w_accept;
    logic             r_drop;

    // Only outputs that exist can match, so an out-of-range select leaves
    // w_hit all zero. This avoids indexing a buffer that is not there.
    assign w_legal     = |w_hit;
    assign inp_ready_o = !rst_i && !flush_i && !(|(w_hit & w_full));
    assign w_accept    = inp_valid_i && inp_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= w_accept && !w_legal;
        end
    end

    assign drop_o = r_drop;

    for (genvar i = 0; i < N_OUP; i++) begin : g_oup
        logic [1:0] r_cnt;
        DATA_T      r_head;
        DATA_T      r_tail;
        logic       w_push;
        logic       w_pop;

        assign w_hit[i]       = (inp_sel_i == SEL_W'(i));
        assign w_full[i]      = (r_cnt == 2'd2);
        assign oup_valid_o[i] = (r_cnt != 2'd0) && !flush_i && !rst_i;
        assign oup_data_o[i]  = r_head;
        assign w_push         = w_accept && w_hit[i];
        assign w_pop          = oup_valid_o[i] && oup_ready_i[i];

        // A push together with a pop can only happen at cnt 1: at cnt 0 the
        // output is not valid, and at cnt 2 the input is not ready.
        always_ff @(posedge clk_i) begin
            if (rst_i || flush_i) begin
                r_cnt <= 2'd0;
            end else if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 2'd1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end

        // Payload storage is not reset. Occupancy alone decides what is live.
        always_ff @(posedge clk_i) begin
            if (w_push && (r_cnt == 2'd0 || w_pop)) begin
                r_head <= inp_data_i;
            end else if (w_push) begin
                r_tail <= inp_data_i;
            end else if (w_pop && r_cnt == 2'd2) begin
                r_head <= r_tail;
            end
        end
    end

endmodule

// File: tb/tb_stream_demux_flushable.sv
module tb_stream_demux_flushable;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // DUT A: four outputs, every select value is legal
    logic            rst;
    logic            a_flush;
    logic [7:0]      a_data;
    logic [1:0]      a_sel;
    logic            a_valid;
    logic            a_ready;
    logic [3:0][7:0] a_odata;
    logic [3:0]      a_ovalid;
    logic [3:0]      a_oready;
    logic            a_drop;

    // DUT B: three outputs, so select 3 is out of range
    logic            b_flush;
    logic [7:0]      b_data;
    logic [1:0]      b_sel;
    logic            b_valid;
    logic            b_ready;
    logic [2:0][7:0] b_odata;
    logic [2:0]      b_ovalid;
    logic [2:0]      b_oready;
    logic            b_drop;

    stream_demux_flushable #(.DATA_T(logic [7:0]), .N_OUP(4)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(a_flush),
        .inp_data_i(a_data), .inp_sel_i(a_sel), .inp_valid_i(a_valid),
        .inp_ready_o(a_ready), .oup_data_o(a_odata), .oup_valid_o(a_ovalid),
        .oup_ready_i(a_oready), .drop_o(a_drop)
    );

    stream_demux_flushable #(.DATA_T(logic [7:0]), .N_OUP(3)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(b_flush),
        .inp_data_i(b_data), .inp_sel_i(b_sel), .inp_valid_i(b_valid),
        .inp_ready_o(b_ready), .oup_data_o(b_odata), .oup_valid_o(b_ovalid),
        .oup_ready_i(b_oready), .drop_o(b_drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; a_flush = 1'b0; b_flush = 1'b0;
        a_valid = 1'b1; a_sel = 2'd0; a_data = 8'h99; a_oready = 4'hF;
        b_valid = 1'b1; b_sel = 2'd3; b_data = 8'h99; b_oready = 3'h7;

        // Reset held for three cycles with the input valid
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            chk("rst_ready", a_ready, 0);
            chk("rst_valid", a_ovalid, 4'b0000);
            chk("rst_drop", a_drop, 0);
            chk("rst_b_drop", b_drop, 0);
        end
        rst = 1'b0; b_valid = 1'b0;

        // Throughput: 0x10..0x13 to sel 2, back to back
        a_sel = 2'd2; a_valid = 1'b1; a_oready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            a_data = 8'h10 + 8'(k);
            #1;
            chk("tp_ready", a_ready, 1);
            if (k == 0) chk("tp_first_empty", a_ovalid, 4'b0000);
            else begin
                chk("tp_valid", a_ovalid, 4'b0100);
                chk("tp_data", a_odata[2], 8'h10 + 8'(k - 1));
            end
            tick();
        end
        a_valid = 1'b0; #1;
        chk("tp_last_valid", a_ovalid, 4'b0100);
        chk("tp_last_data", a_odata[2], 8'h13);
        tick(); #1;
        chk("tp_drained", a_ovalid, 4'b0000);

        // Backpressure on output 1
        a_oready = 4'b1101; a_valid = 1'b1; a_sel = 2'd1; a_data = 8'hA0; #1;
        chk("bp_acc_a0", a_ready, 1);
        tick();
        a_data = 8'hA1; #1;
        chk("bp_acc_a1", a_ready, 1);
        chk("bp_head_a0", a_odata[1], 8'hA0);
        tick();
        a_data = 8'hA2; #1;
        chk("bp_full_block", a_ready, 0);
        chk("bp_valid1", a_ovalid, 4'b0010);
        tick();
        a_sel = 2'd3; a_data = 8'hB0; #1;
        chk("bp_other_ready", a_ready, 1);
        tick();
        a_sel = 2'd1; a_data = 8'hA2; a_oready = 4'hF; #1;
        chk("bp_ready_indep", a_ready, 0);
        chk("bp_stable_data", a_odata[1], 8'hA0);
        chk("bp_valid_13", a_ovalid, 4'b1010);
        chk("bp_b0_data", a_odata[3], 8'hB0);
        tick(); #1;
        chk("bp_head_a1", a_odata[1], 8'hA1);
        chk("bp_acc_a2", a_ready, 1);
        chk("bp_valid_1only", a_ovalid, 4'b0010);
        tick();
        a_valid = 1'b0; #1;
        chk("bp_head_a2", a_odata[1], 8'hA2);
        chk("bp_valid_a2", a_ovalid, 4'b0010);
        tick(); #1;
        chk("bp_drained", a_ovalid, 4'b0000);

        // Simultaneous push and pop on output 0 at occupancy 1
        a_oready = 4'b0000; a_valid = 1'b1; a_sel = 2'd0; a_data = 8'h55;
        tick();
        a_data = 8'h66; a_oready = 4'b0001; #1;
        chk("pp_head55", a_odata[0], 8'h55);
        chk("pp_ready", a_ready, 1);
        tick();
        a_valid = 1'b0; a_oready = 4'b0000; #1;
        chk("pp_head66", a_odata[0], 8'h66);
        chk("pp_valid", a_ovalid, 4'b0001);
        tick(); #1;
        chk("pp_hold66", a_odata[0], 8'h66);
        a_oready = 4'b0001;
        tick(); #1;
        chk("pp_no_dup", a_ovalid, 4'b0000);

        // Flush with buffers 0 and 3 full
        a_oready = 4'b0000; a_valid = 1'b1;
        a_sel = 2'd0; a_data = 8'h01; tick();
        a_data = 8'h02; tick();
        a_sel = 2'd3; a_data = 8'h03; tick();
        a_data = 8'h04; tick();
        a_sel = 2'd0; a_data = 8'h05; #1;
        chk("fl_full0", a_ready, 0);
        chk("fl_pre_valid", a_ovalid, 4'b1001);
        a_flush = 1'b1; a_sel = 2'd1; a_data = 8'h09; #1;
        chk("fl_valid_low", a_ovalid, 4'b0000);
        chk("fl_ready_low", a_ready, 0);
        tick();
        a_flush = 1'b0; a_valid = 1'b0; a_oready = 4'hF; #1;
        chk("fl_empty", a_ovalid, 4'b0000);
        a_valid = 1'b1; a_sel = 2'd0; a_data = 8'h77; #1;
        chk("fl_resume_ready", a_ready, 1);
        tick();
        a_valid = 1'b0; #1;
        chk("fl_77_valid", a_ovalid, 4'b0001);
        chk("fl_77_data", a_odata[0], 8'h77);
        tick(); #1;
        chk("fl_drained", a_ovalid, 4'b0000);

        // Flush held for two cycles while the input stays valid
        a_flush = 1'b1; a_valid = 1'b1; a_sel = 2'd2; a_data = 8'h3C;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("flh_ready", a_ready, 0);
            tick();
        end
        a_flush = 1'b0; a_valid = 1'b0; #1;
        chk("flh_empty", a_ovalid, 4'b0000);

        // Mid-operation reset clears a stalled buffer
        a_oready = 4'b0000; a_valid = 1'b1; a_sel = 2'd2; a_data = 8'h5A;
        tick();
        a_valid = 1'b0; rst = 1'b1; #1;
        chk("mrst_valid_low", a_ovalid, 4'b0000);
        tick();
        rst = 1'b0; #1;
        chk("mrst_empty", a_ovalid, 4'b0000);

        // Out-of-range select on the three-output instance
        b_valid = 1'b1; b_sel = 2'd3; b_data = 8'hEE; #1;
        chk("ill_ready", b_ready, 1);
        chk("ill_drop_before", b_drop, 0);
        tick();
        b_valid = 1'b0; #1;
        chk("ill_drop", b_drop, 1);
        chk("ill_no_valid", b_ovalid, 3'b000);
        tick(); #1;
        chk("ill_drop_once", b_drop, 0);
        chk("ill_still_empty", b_ovalid, 3'b000);
        b_valid = 1'b1; b_sel = 2'd2; b_data = 8'h5A;
        tick();
        b_valid = 1'b0; #1;
        chk("b_legal_valid", b_ovalid, 3'b100);
        chk("b_legal_data", b_odata[2], 8'h5A);
        chk("b_legal_nodrop", b_drop, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
